// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared field widths, constants and FSM encoding for the
//               sequential FP32 adder.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXT_W    = 27;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

    localparam logic [31:0]      C_QNAN       = 32'h7FC0_0000;
    localparam logic [EXP_W+MAN_W-1:0] C_INF  = 31'h7F80_0000;
    localparam logic [EXP_W+MAN_W-1:0] C_MAX_FINITE = 31'h7F7F_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXP   = 3'd1,
        ST_ALIGN = 3'd2,
        ST_ADD   = 3'd3,
        ST_NORM  = 3'd4,
        ST_ROUND = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_add_seq_small_alu.sv
`default_nettype none
// ============================================================================
// Module      : small_alu
// Description : Exponent-difference unit; diff = ea - eb (mod 256) plus the
//               borrow that tells the sequencer ea < eb.
// Revision    : 1.0 - initial release
// ============================================================================
module small_alu
    import fp32_pkg::*;
(
    input  logic [EXP_W-1:0] ea,
    input  logic [EXP_W-1:0] eb,
    output logic [EXP_W-1:0] diff,
    output logic             borrow
);

    logic [EXP_W:0] w_sub;

    assign w_sub  = {1'b0, ea} - {1'b0, eb};
    assign diff   = w_sub[EXP_W-1:0];
    assign borrow = w_sub[EXP_W];

endmodule
`default_nettype wire

// File: rtl/fp32_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_add_seq
// Description : Multi-cycle FP32 adder sequencer (align/add/normalize/RNE,
//               one shift per cycle). Macro FP32_ADD_SPECIALS_EN enables
//               Inf/NaN handling; otherwise overflow saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_add_seq
    import fp32_pkg::*;
#(
    parameter int MAX_ALIGN = 26
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic [EXP_W-1:0] C_MAX_ALIGN = EXP_W'(MAX_ALIGN);
    localparam logic [9:0]       C_EXP_MAX   = 10'(EXP_MAX);
`ifdef FP32_ADD_SPECIALS_EN
    localparam logic [EXP_W+MAN_W-1:0] C_OVF = C_INF;
`else
    localparam logic [EXP_W+MAN_W-1:0] C_OVF = C_MAX_FINITE;
`endif

    state_t             r_state;
    logic               r_in_ready, r_out_valid, r_busy;
    logic [31:0]        r_result, r_a, r_b;
    logic               r_sign_l, r_sub, r_neg_zero;
    logic [9:0]         r_exp;
    logic [EXT_W-1:0]   r_man_l, r_man_s;
    logic [EXT_W:0]     r_sum;
    logic [EXP_W-1:0]   r_cnt;

    logic [31:0]        w_a_flush, w_b_flush;
    logic [EXP_W-1:0]   w_ea, w_eb, w_diff, w_shift, w_n;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic [EXT_W-1:0]   w_ext_a, w_ext_b;
    logic               w_borrow, w_swap;
    logic               w_inc;
    logic [24:0]        w_rnd;
    logic [9:0]         w_rexp;
    logic [MAN_W-1:0]   w_rman;
    logic [31:0]        w_pack;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;

    // Denormal inputs are flushed to signed zero on capture.
    assign w_a_flush = (a[30:23] == '0) ? {a[31], 31'd0} : a;
    assign w_b_flush = (b[30:23] == '0) ? {b[31], 31'd0} : b;

    assign w_ea = r_a[30:23];
    assign w_eb = r_b[30:23];
    assign w_ma = r_a[22:0];
    assign w_mb = r_b[22:0];

    small_alu u_small_alu (
        .ea     (w_ea),
        .eb     (w_eb),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign w_swap  = w_borrow | ((w_ea == w_eb) & (w_ma < w_mb));
    assign w_shift = w_swap ? (-w_diff) : w_diff;
    assign w_n     = (w_shift > C_MAX_ALIGN) ? C_MAX_ALIGN : w_shift;
    assign w_ext_a = {(w_ea != '0), w_ma, 3'b000};
    assign w_ext_b = {(w_eb != '0), w_mb, 3'b000};

`ifdef FP32_ADD_SPECIALS_EN
    logic        w_special, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [31:0] w_special_res;

    always_comb begin
        w_nan_a   = (w_ea == '1) & (w_ma != '0);
        w_nan_b   = (w_eb == '1) & (w_mb != '0);
        w_inf_a   = (w_ea == '1) & (w_ma == '0);
        w_inf_b   = (w_eb == '1) & (w_mb == '0);
        w_special = (w_ea == '1) | (w_eb == '1);
        if (w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (r_a[31] ^ r_b[31])))
            w_special_res = C_QNAN;
        else if (w_inf_a)
            w_special_res = {r_a[31], C_INF};
        else
            w_special_res = {r_b[31], C_INF};
    end
`endif

    // Round-to-nearest-even on the normalized {hidden, frac, G, R, S} word.
    always_comb begin
        w_inc  = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
        w_rnd  = {1'b0, r_sum[26:3]} + {24'd0, w_inc};
        w_rexp = r_exp + {9'd0, w_rnd[24]};
        w_rman = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
        if (r_sum == '0)
            w_pack = {r_neg_zero, 31'd0};
        else if (!r_sum[26])
            w_pack = {r_sign_l, 31'd0};
        else if (w_rexp >= C_EXP_MAX)
            w_pack = {r_sign_l, C_OVF};
        else
            w_pack = {r_sign_l, w_rexp[7:0], w_rman};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sign_l    <= 1'b0;
            r_sub       <= 1'b0;
            r_neg_zero  <= 1'b0;
            r_exp       <= '0;
            r_man_l     <= '0;
            r_man_s     <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= w_a_flush;
                        r_b        <= w_b_flush;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_EXP;
                    end
                end
                ST_EXP: begin
`ifdef FP32_ADD_SPECIALS_EN
                    if (w_special) begin
                        r_result    <= w_special_res;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else
`endif
                    begin
                        r_sign_l   <= w_swap ? r_b[31] : r_a[31];
                        r_sub      <= r_a[31] ^ r_b[31];
                        r_neg_zero <= (r_a == 32'h8000_0000) & (r_b == 32'h8000_0000);
                        r_exp      <= {2'b00, (w_swap ? w_eb : w_ea)};
                        r_man_l    <= w_swap ? w_ext_b : w_ext_a;
                        r_man_s    <= w_swap ? w_ext_a : w_ext_b;
                        r_cnt      <= w_n;
                        r_state    <= (w_n != '0) ? ST_ALIGN : ST_ADD;
                    end
                end
                ST_ALIGN: begin
                    // The bit leaving position 0 folds into the sticky bit.
                    r_man_s <= {1'b0, r_man_s[EXT_W-1:2], r_man_s[1] | r_man_s[0]};
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == 8'd1)
                        r_state <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_man_l} - {1'b0, r_man_s})
                                     : ({1'b0, r_man_l} + {1'b0, r_man_s});
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    if (r_sum == '0) begin
                        r_state <= ST_ROUND;
                    end else if (r_sum[EXT_W]) begin
                        r_sum <= {1'b0, r_sum[EXT_W:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + 10'd1;
                    end else if (!r_sum[EXT_W-1] && (r_exp > 10'd1)) begin
                        r_sum <= {r_sum[EXT_W-1:0], 1'b0};
                        r_exp <= r_exp - 10'd1;
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_result    <= w_pack;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
